// File: rtl/cdc_sync_pkg.sv
// Shared limits and counter sizing for the filtered bit synchroniser.
// Optional sticky change flags are enabled with CDC_SYNC_STICKY_EN.
package cdc_sync_pkg;

  localparam int CDC_SYNC_MIN_STAGES = 2;
  localparam int CDC_SYNC_MAX_STAGES = 4;
  localparam int CDC_FILTER_MAX_LEN  = 255;

  function automatic int cdc_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // A filter length of 1 still needs a 1-bit counter to keep the ports legal.
  function automatic int cdc_cnt_width(input int len);
    return (cdc_clog2(len) < 1) ? 1 : cdc_clog2(len);
  endfunction

endpackage

// File: rtl/cdc_glitch_filter.sv
// One channel: stability counter, filtered level and edge pulses.
// With CDC_SYNC_STICKY_EN a change-seen flag is added.
module cdc_glitch_filter
  import cdc_sync_pkg::*;
#(
  parameter int   FILTER_LEN = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic out_clk,
  input  logic out_resetn,
  input  logic sync,
  output logic out,
  output logic out_rise,
`ifdef CDC_SYNC_STICKY_EN
  input  logic sticky_clr,
  output logic out_sticky,
`endif
  output logic out_fall
);

  localparam int             CNT_W    = cdc_cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge out_clk) begin
    if (!out_resetn) begin
      cnt      <= '0;
      out      <= RESET_VAL;
      out_rise <= 1'b0;
      out_fall <= 1'b0;
    end else begin
      out_rise <= 1'b0;
      out_fall <= 1'b0;
      if (sync == out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Pulses land in the same cycle the new level first shows on out.
        out      <= sync;
        cnt      <= '0;
        out_rise <= sync;
        out_fall <= ~sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef CDC_SYNC_STICKY_EN
  // Set has priority over clear so an event arriving with a clear is kept.
  always_ff @(posedge out_clk) begin
    if (!out_resetn) out_sticky <= 1'b0;
    else             out_sticky <= out_rise | out_fall | (out_sticky & ~sticky_clr);
  end
`endif

endmodule

// File: rtl/cdc_sync_bits_filt.sv
// Multi-channel synchroniser with per-channel glitch filter and edge pulses.
// Define CDC_SYNC_STICKY_EN to add sticky_clr / out_sticky.
module cdc_sync_bits_filt
  import cdc_sync_pkg::*;
#(
  parameter int                     NUM_OF_BITS = 1,
  parameter int                     ASYNC_CLK   = 1,
  parameter int                     SYNC_STAGES = 2,
  parameter int                     FILTER_LEN  = 4,
  parameter logic [NUM_OF_BITS-1:0] RESET_VAL   = '0
) (
  input  logic                   out_clk,
  input  logic                   out_resetn,
  input  logic [NUM_OF_BITS-1:0] in,
  output logic [NUM_OF_BITS-1:0] out,
  output logic [NUM_OF_BITS-1:0] out_rise,
`ifdef CDC_SYNC_STICKY_EN
  input  logic [NUM_OF_BITS-1:0] sticky_clr,
  output logic [NUM_OF_BITS-1:0] out_sticky,
`endif
  output logic [NUM_OF_BITS-1:0] out_fall
);

  if (ASYNC_CLK != 0 &&
      (SYNC_STAGES < CDC_SYNC_MIN_STAGES || SYNC_STAGES > CDC_SYNC_MAX_STAGES)) begin : g_bad_stages
    $error("cdc_sync_bits_filt: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, CDC_SYNC_MIN_STAGES, CDC_SYNC_MAX_STAGES);
  end

  if (FILTER_LEN < 1 || FILTER_LEN > CDC_FILTER_MAX_LEN) begin : g_bad_filter
    $error("cdc_sync_bits_filt: FILTER_LEN=%0d outside 1..%0d",
           FILTER_LEN, CDC_FILTER_MAX_LEN);
  end

  logic [NUM_OF_BITS-1:0] sync;

  if (ASYNC_CLK != 0) begin : g_sync
    (* ASYNC_REG = "TRUE" *) logic [NUM_OF_BITS-1:0] stage [SYNC_STAGES];

    always_ff @(posedge out_clk) begin
      if (!out_resetn) begin
        for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= RESET_VAL;
      end else begin
        stage[0] <= in;
        for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
      end
    end

    assign sync = stage[SYNC_STAGES-1];
  end else begin : g_bypass
    assign sync = in;
  end

  for (genvar i = 0; i < NUM_OF_BITS; i++) begin : g_chan
    cdc_glitch_filter #(
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_VAL[i])
    ) u_filt (
      .out_clk    (out_clk),
      .out_resetn (out_resetn),
      .sync       (sync[i]),
      .out        (out[i]),
      .out_rise   (out_rise[i]),
`ifdef CDC_SYNC_STICKY_EN
      .sticky_clr (sticky_clr[i]),
      .out_sticky (out_sticky[i]),
`endif
      .out_fall   (out_fall[i])
    );
  end

endmodule

// File: tb/tb_cdc_sync_bits_filt.sv
// Scoreboard bench: three configurations of cdc_sync_bits_filt on one clock.
// Expected values are queued with their due cycle and compared on the falling edge.
module tb_cdc_sync_bits_filt;

  // a: SS=2 FL=4, b: bypass FL=1, c: SS=3 FL=8
  localparam int A_OUT = 0, A_RISE = 1, A_FALL = 2;
  localparam int B_OUT = 3, B_RISE = 4, B_FALL = 5;
  localparam int C_OUT = 6, C_RISE = 7, C_FALL = 8;
  localparam int A_STICKY = 9;

  logic clk;
  logic rst_n;
  logic [3:0] in_a, in_b, in_c;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic [3:0] out_c, rise_c, fall_c;
`ifdef CDC_SYNC_STICKY_EN
  logic [3:0] clr_a, clr_b, clr_c;
  logic [3:0] sticky_a, sticky_b, sticky_c;
`endif

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int         cyc;
    int         code;
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  cdc_sync_bits_filt #(.NUM_OF_BITS(4), .ASYNC_CLK(1), .SYNC_STAGES(2), .FILTER_LEN(4)) dut_a (
    .out_clk(clk), .out_resetn(rst_n), .in(in_a), .out(out_a), .out_rise(rise_a),
`ifdef CDC_SYNC_STICKY_EN
    .sticky_clr(clr_a), .out_sticky(sticky_a),
`endif
    .out_fall(fall_a));

  cdc_sync_bits_filt #(.NUM_OF_BITS(4), .ASYNC_CLK(0), .SYNC_STAGES(2), .FILTER_LEN(1)) dut_b (
    .out_clk(clk), .out_resetn(rst_n), .in(in_b), .out(out_b), .out_rise(rise_b),
`ifdef CDC_SYNC_STICKY_EN
    .sticky_clr(clr_b), .out_sticky(sticky_b),
`endif
    .out_fall(fall_b));

  cdc_sync_bits_filt #(.NUM_OF_BITS(4), .ASYNC_CLK(1), .SYNC_STAGES(3), .FILTER_LEN(8)) dut_c (
    .out_clk(clk), .out_resetn(rst_n), .in(in_c), .out(out_c), .out_rise(rise_c),
`ifdef CDC_SYNC_STICKY_EN
    .sticky_clr(clr_c), .out_sticky(sticky_c),
`endif
    .out_fall(fall_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] get_sig(input int code);
    case (code)
      A_OUT:  return out_a;
      A_RISE: return rise_a;
      A_FALL: return fall_a;
      B_OUT:  return out_b;
      B_RISE: return rise_b;
      B_FALL: return fall_b;
      C_OUT:  return out_c;
      C_RISE: return rise_c;
      C_FALL: return fall_c;
`ifdef CDC_SYNC_STICKY_EN
      A_STICKY: return sticky_a;
`endif
      default: return 4'hx;
    endcase
  endfunction

  task automatic push(input int c, input int code, input logic [3:0] v, input string tag);
    exp_t e;
    e.cyc = c; e.code = code; e.exp = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_range(input int c0, input int c1, input int code,
                            input logic [3:0] v, input string tag);
    for (int c = c0; c <= c1; c++) push(c, code, v, tag);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, 32'(get_sig(sb[i].code)), 32'(sb[i].exp));
        sb.delete(i);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in_a   = 4'hF;
    in_b   = 4'h0;
    in_c   = 4'h0;
`ifdef CDC_SYNC_STICKY_EN
    clr_a = 4'h0; clr_b = 4'h0; clr_c = 4'h0;
`endif

    // Reset with in=F, then clean step: 6 edges after release.
    push_range(1, 5, A_OUT,  4'h0, "rst_out_a");
    push_range(1, 5, A_RISE, 4'h0, "rst_rise_a");
    push_range(1, 5, C_OUT,  4'h0, "rst_out_c");
    push_range(6, 10, A_OUT, 4'h0, "step_out_early");
    push(11, A_OUT,  4'hF, "step_out");
    push(11, A_RISE, 4'hF, "step_rise");
    push_range(6, 10, A_RISE, 4'h0, "step_rise_early");
    push(12, A_RISE, 4'h0, "step_rise_once");
    push_range(1, 18, A_FALL, 4'h0, "step_fall_none");
`ifdef CDC_SYNC_STICKY_EN
    push(5,  A_STICKY, 4'h0, "sticky_rst");
    push(11, A_STICKY, 4'h0, "sticky_pre");
    push(12, A_STICKY, 4'hF, "sticky_set");
`endif
    go_to(5);
    rst_n = 1'b1;

    // Bring ch0 low, then a 3-cycle glitch (rejected) and a 4-cycle pulse (accepted).
    push(18, A_OUT,  4'hF, "ch0_low_early");
    push(19, A_OUT,  4'hE, "ch0_low");
    push(19, A_FALL, 4'h1, "ch0_fall");
    push_range(20, 39, A_OUT,  4'hE, "glitch_out");
    push_range(20, 39, A_RISE, 4'h0, "glitch_rise");
    push_range(20, 43, A_FALL, 4'h0, "glitch_fall");
    push_range(40, 43, A_OUT,  4'hF, "pulse4_out");
    push(40, A_RISE, 4'h1, "pulse4_rise");
    push_range(41, 45, A_RISE, 4'h0, "pulse4_rise_once");
    push(44, A_OUT,  4'hE, "pulse4_back");
    push(44, A_FALL, 4'h1, "pulse4_fall");
    push(45, A_FALL, 4'h0, "pulse4_fall_once");
    go_to(13); in_a = 4'hE;
    go_to(22); in_a = 4'hF;
    go_to(25); in_a = 4'hE;
    go_to(34); in_a = 4'hF;
    go_to(38); in_a = 4'hE;

    // Bypass, FILTER_LEN=1: next-edge response.
    push(46, B_OUT,  4'h0, "byp_out_early");
    push(47, B_OUT,  4'h1, "byp_out");
    push(47, B_RISE, 4'h1, "byp_rise");
    push(47, B_FALL, 4'h0, "byp_fall_none");
    push(48, B_RISE, 4'h0, "byp_rise_once");
    push(50, B_OUT,  4'h0, "byp_out_low");
    push(50, B_FALL, 4'h1, "byp_fall");
    push(51, B_FALL, 4'h0, "byp_fall_once");
    go_to(46); in_b = 4'h1;
    go_to(49); in_b = 4'h0;

    // Independence: 0101 then 1010 on SS=3 FL=8, latency 11.
    push(62, C_OUT,  4'h0, "ind_out_early");
    push(63, C_OUT,  4'h5, "ind_out_5");
    push(63, C_RISE, 4'h5, "ind_rise_5");
    push(76, C_OUT,  4'h5, "ind_out_hold");
    push(77, C_OUT,  4'hA, "ind_out_a");
    push(77, C_RISE, 4'hA, "ind_rise_a");
    push(77, C_FALL, 4'h5, "ind_fall_5");
    push(78, C_RISE, 4'h0, "ind_rise_once");
    push(78, C_FALL, 4'h0, "ind_fall_once");
    go_to(52); in_c = 4'h5;
    go_to(66); in_c = 4'hA;

    // ch1 toggling every cycle never gets through.
    push_range(80, 108, A_OUT,  4'hE, "toggle_out");
    push_range(80, 108, A_RISE, 4'h0, "toggle_rise");
    push_range(80, 108, A_FALL, 4'h0, "toggle_fall");
    for (int k = 80; k < 100; k++) begin
      go_to(k);
      in_a = in_a ^ 4'h2;
    end

    // Clear everything, then reset while ch1's count is at 2.
    push(115, A_OUT,  4'hE, "clr_out_early");
    push(116, A_OUT,  4'h0, "clr_out");
    push(116, A_FALL, 4'hE, "clr_fall");
    push(125, A_OUT,  4'h0, "mid_rst_out");
    push_range(125, 130, A_RISE, 4'h0, "mid_rst_rise_none");
    push(130, A_OUT,  4'h0, "mid_rst_out_early");
    push(131, A_OUT,  4'h2, "mid_rst_out");
    push(131, A_RISE, 4'h2, "mid_rst_rise");
    push_range(132, 139, A_RISE, 4'h0, "mid_rst_rise_once");
    push(125, C_OUT,  4'h0, "c_rst_out");
    push_range(125, 135, C_RISE, 4'h0, "c_rst_rise_none");
    push(136, C_OUT,  4'hA, "c_rst_out_back");
    push(136, C_RISE, 4'hA, "c_rst_rise");
    push_range(125, 140, C_FALL, 4'h0, "c_rst_fall_none");
`ifdef CDC_SYNC_STICKY_EN
    push(125, A_STICKY, 4'h0, "sticky_rst2");
    push(131, A_STICKY, 4'h0, "sticky_pre2");
    push(132, A_STICKY, 4'h2, "sticky_ch1");
`endif
    go_to(110); in_a = 4'h0;
    go_to(120); in_a = 4'h2;
    go_to(124); rst_n = 1'b0;
    go_to(125); rst_n = 1'b1;

    // ch2 rise; clear in the pulse cycle must lose to the set.
    push(146, A_OUT,  4'h6, "ch2_out");
    push(146, A_RISE, 4'h4, "ch2_rise");
`ifdef CDC_SYNC_STICKY_EN
    push(146, A_STICKY, 4'h2, "sticky_pre3");
    push(147, A_STICKY, 4'h6, "sticky_set_wins");
    push(150, A_STICKY, 4'h6, "sticky_hold");
    push(151, A_STICKY, 4'h2, "sticky_clr");
`endif
    go_to(140); in_a = 4'h6;
`ifdef CDC_SYNC_STICKY_EN
    go_to(146); clr_a = 4'h4;
    go_to(147); clr_a = 4'h0;
    go_to(150); clr_a = 4'h4;
    go_to(151); clr_a = 4'h0;
`endif

    go_to(160);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
